boss_fight_ctrl: RTL

// Sequences the final-boss encounter: waits for the enemy wave to clear, runs an intro delay, then enables the boss.

---
 rtl/boss_fight_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/boss_fight_ctrl.sv
// Final-boss encounter sequencer: intro delay, shot scheduling, hit-driven fire rate, win/loss.
// Optional BOSS_SHOT_AIM_EN: last-hit-before-death shots aim at the player's Y.
module boss_fight_ctrl #(
  parameter int unsigned INTRO_FRAMES = 120,
  parameter int unsigned FIRE_PERIOD  = 60,
  parameter int unsigned FIRE_STEP    = 15,
  parameter int unsigned MIN_PERIOD   = 10,
  parameter int unsigned BOSS_HP      = 3,
  parameter int unsigned WIN_FRAMES   = 180
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       enemies_cleared,
  input  logic       player_dead,
  input  logic       restart,
  input  logic       boss_hit,
  input  logic       boss_dead,
  input  logic [9:0] boss_x,
  input  logic [8:0] boss_y,
  input  logic [8:0] player_y,
  input  logic       shot_ready,
  output logic       boss_active,
  output logic       boss_rearm,
  output logic       shot_fire,
  output logic [9:0] shot_x,
  output logic [8:0] shot_y,
  output logic [1:0] hits_taken,
  output logic [2:0] phase,
  output logic       game_won,
  output logic       game_lost
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned HIT_W = 2;
  localparam int unsigned Y_W   = 9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INTRO = 3'd1,
    S_FIGHT = 3'd2,
    S_WIN   = 3'd3,
    S_WON   = 3'd4,
    S_LOST  = 3'd5
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   frame_cnt;
  logic [CNT_W-1:0]   fire_cnt;
  logic               pending;
  logic               hit_prev;

  logic [31:0]        red;
  logic [CNT_W-1:0]   period;
  logic               fire_reach;
  logic               pend_now;
  logic               hit_rise;
  logic [Y_W-1:0]     spawn_y;

  // Shot period shrinks with hits; guarded so the subtraction never wraps.
  always_comb begin
    red    = 32'(hits_taken) * FIRE_STEP;
    period = CNT_W'(MIN_PERIOD);
    if (FIRE_PERIOD > red && (FIRE_PERIOD - red) > MIN_PERIOD)
      period = CNT_W'(FIRE_PERIOD - red);
  end

  always_comb begin
    fire_reach = frame_tick && ((fire_cnt + CNT_W'(1)) >= period);
    pend_now   = pending || fire_reach;
    hit_rise   = boss_hit && !hit_prev;
  end

`ifdef BOSS_SHOT_AIM_EN
  logic [Y_W:0] aim_lo;
  logic [Y_W:0] aim_hi;
  logic [Y_W:0] aim_py;

  // One hit from death, the boss aims within its own 32-pixel-high band.
  always_comb begin
    aim_lo  = {1'b0, boss_y};
    aim_hi  = aim_lo + (Y_W+1)'(31);
    aim_py  = {1'b0, player_y};
    spawn_y = boss_y + Y_W'(16);
    if (hits_taken == HIT_W'(BOSS_HP - 1)) begin
      if (aim_py < aim_lo)      spawn_y = aim_lo[Y_W-1:0];
      else if (aim_py > aim_hi) spawn_y = aim_hi[Y_W-1:0];
      else                      spawn_y = aim_py[Y_W-1:0];
    end
  end
`else
  logic unused_player_y;

  assign unused_player_y = ^player_y;

  always_comb begin
    spawn_y = boss_y + Y_W'(16);
  end
`endif

  assign phase = 3'(state);

  // Encounter FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      frame_cnt   <= '0;
      fire_cnt    <= '0;
      pending     <= 1'b0;
      hit_prev    <= 1'b0;
      boss_active <= 1'b0;
      boss_rearm  <= 1'b0;
      shot_fire   <= 1'b0;
      shot_x      <= '0;
      shot_y      <= '0;
      hits_taken  <= '0;
      game_won    <= 1'b0;
      game_lost   <= 1'b0;
    end else begin
      hit_prev   <= boss_hit;
      shot_fire  <= 1'b0;
      boss_rearm <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enemies_cleared) begin
            state     <= S_INTRO;
            frame_cnt <= '0;
          end
        end
        S_INTRO: begin
          if (frame_tick) begin
            if (frame_cnt == CNT_W'(INTRO_FRAMES - 1)) begin
              state       <= S_FIGHT;
              boss_active <= 1'b1;
              fire_cnt    <= '0;
              hits_taken  <= '0;
              pending     <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end
        S_FIGHT: begin
          if (player_dead) begin
            state       <= S_LOST;
            boss_active <= 1'b0;
            game_lost   <= 1'b1;
            pending     <= 1'b0;
          end else if (boss_dead) begin
            state       <= S_WIN;
            boss_active <= 1'b0;
            frame_cnt   <= '0;
            pending     <= 1'b0;
          end else begin
            if (hit_rise && hits_taken < HIT_W'(BOSS_HP))
              hits_taken <= hits_taken + HIT_W'(1);
            // A due shot waits here, counter parked, until the slot frees.
            if (pend_now && shot_ready) begin
              shot_fire <= 1'b1;
              shot_x    <= boss_x;
              shot_y    <= spawn_y;
              pending   <= 1'b0;
              fire_cnt  <= '0;
            end else if (pend_now) begin
              pending  <= 1'b1;
              fire_cnt <= period;
            end else if (frame_tick) begin
              fire_cnt <= fire_cnt + CNT_W'(1);
            end
          end
        end
        S_WIN: begin
          if (frame_tick) begin
            if (frame_cnt == CNT_W'(WIN_FRAMES - 1)) begin
              state    <= S_WON;
              game_won <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end
        S_WON, S_LOST: begin
          if (restart) begin
            state      <= S_IDLE;
            game_won   <= 1'b0;
            game_lost  <= 1'b0;
            boss_rearm <= 1'b1;
            hits_taken <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
